// File: rtl/fifo_ctrl.sv
// Write-arbitration and read-drain controller for a single-port 32-bit FIFO.
// Round-robin grants feed the write port; a 2-entry buffer hides the FIFO read latency.
module fifo_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NREQ-1:0]            i_req_valid,
  input  logic [NREQ*WIDTH-1:0]      i_req_data,
  output logic [NREQ-1:0]            o_req_ready,
  output logic                       o_cs,
  output logic                       o_wr_en,
  output logic                       o_rd_en,
  output logic [WIDTH-1:0]           o_data_in,
  input  logic [WIDTH-1:0]           i_data_out,
  input  logic                       i_empty,
  input  logic                       i_full,
  output logic                       o_out_valid,
  output logic [WIDTH-1:0]           o_out_data,
  input  logic                       i_out_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = $clog2(NREQ);

  logic [LW-1:0]    r_last;
  logic [CW-1:0]    r_count;
  logic             r_inflight;
  logic [WIDTH-1:0] r_obuf [2];
  logic [1:0]       r_obuf_cnt;
  logic             r_err;

  logic [LW-1:0]    w_idx;
  logic [LW-1:0]    w_sel;
  logic             w_any;
  logic             w_wr;
  logic             w_rd;
  logic             w_pop;

  // Scan requesters starting just after the last grant, wrapping at NREQ.
  always_comb begin
    w_idx = r_last;
    w_sel = r_last;
    w_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (w_idx == LW'(NREQ-1)) ? '0 : w_idx + LW'(1);
      if (!w_any && i_req_valid[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_wr  = i_rst_n & w_any & (r_count != CW'(DEPTH));
  assign w_pop = o_out_valid & i_out_ready;
  // Issue a read only if the word is guaranteed a free buffer slot when it lands.
  assign w_rd  = i_rst_n & (r_count != '0) &
                 (({1'b0, r_obuf_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  assign o_req_ready = w_wr ? (NREQ'(1) << w_sel) : '0;
  assign o_data_in   = w_wr ? i_req_data[int'(w_sel)*WIDTH +: WIDTH] : '0;
  assign o_wr_en     = w_wr;
  assign o_rd_en     = w_rd;
  assign o_cs        = w_wr | w_rd;
  assign o_out_valid = (r_obuf_cnt != 2'd0);
  assign o_out_data  = r_obuf[0];
  assign o_count     = r_count;
  assign o_err       = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last     <= LW'(NREQ-1);
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (w_wr)
        r_last <= w_sel;
      if (w_wr && !w_rd)
        r_count <= r_count + CW'(1);
      else if (!w_wr && w_rd)
        r_count <= r_count - CW'(1);
      if ((i_empty != (r_count == '0)) || (i_full != (r_count == CW'(DEPTH))))
        r_err <= 1'b1;
    end
  end

  // Entry 0 is always the oldest word; a pop shifts entry 1 down.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_obuf[0]  <= '0;
      r_obuf[1]  <= '0;
      r_obuf_cnt <= 2'd0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_obuf_cnt == 2'd0)
            r_obuf[0] <= i_data_out;
          else
            r_obuf[1] <= i_data_out;
          r_obuf_cnt <= r_obuf_cnt + 2'd1;
        end
        2'b01: begin
          r_obuf[0]  <= r_obuf[1];
          r_obuf_cnt <= r_obuf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_obuf_cnt == 2'd1) begin
            r_obuf[0] <= i_data_out;
          end else begin
            r_obuf[0] <= r_obuf[1];
            r_obuf[1] <= i_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 16x32 FIFO attached to its write/read ports.
// Each feature has its own task with inline comparisons against hand-computed values.
module tb_fifo_ctrl;

  logic         clk;
  logic         rstN;
  logic [3:0]   reqValid;
  logic [127:0] reqData;
  logic [3:0]   reqReady;
  logic         cs;
  logic         wrEn;
  logic         rdEn;
  logic [31:0]  dataIn;
  logic [31:0]  dataOut;
  logic         emptyDut;
  logic         fullDut;
  logic         outValid;
  logic [31:0]  outData;
  logic         outReady;
  logic [4:0]   count;
  logic         err;

  logic         forceEmptyLow;
  logic [31:0]  fifoMem [16];
  logic [4:0]   fifoCnt;
  logic [3:0]   wPtr;
  logic [3:0]   rPtr;

  int           testsRun;
  int           testsFailed;
  int           violations;
  logic [31:0]  gotQ [$];
  logic [31:0]  expQ [$];

  fifo_ctrl #(.NREQ(4), .WIDTH(32), .DEPTH(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_req_valid (reqValid),
    .i_req_data  (reqData),
    .o_req_ready (reqReady),
    .o_cs        (cs),
    .o_wr_en     (wrEn),
    .o_rd_en     (rdEn),
    .o_data_in   (dataIn),
    .i_data_out  (dataOut),
    .i_empty     (emptyDut),
    .i_full      (fullDut),
    .o_out_valid (outValid),
    .o_out_data  (outData),
    .i_out_ready (outReady),
    .o_count     (count),
    .o_err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural FIFO: registered read data, flags derived from its own occupancy.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fifoCnt <= 5'd0;
      wPtr    <= 4'd0;
      rPtr    <= 4'd0;
      dataOut <= 32'd0;
    end else begin
      if (wrEn && fifoCnt != 5'd16) begin
        fifoMem[wPtr] <= dataIn;
        wPtr          <= wPtr + 4'd1;
      end
      if (rdEn && fifoCnt != 5'd0) begin
        dataOut <= fifoMem[rPtr];
        rPtr    <= rPtr + 4'd1;
      end
      fifoCnt <= fifoCnt + 5'(wrEn && fifoCnt != 5'd16) - 5'(rdEn && fifoCnt != 5'd0);
    end
  end

  assign emptyDut = forceEmptyLow ? 1'b0 : (fifoCnt == 5'd0);
  assign fullDut  = (fifoCnt == 5'd16);

  // Record consumer transfers and protocol violations halfway between edges.
  always @(negedge clk) begin
    if (rstN) begin
      if (outValid && outReady) gotQ.push_back(outData);
      if (rdEn && fifoCnt == 5'd0) violations++;
      if (wrEn && fifoCnt == 5'd16) violations++;
      if ($countones(reqReady) > 1) violations++;
      if (cs !== (wrEn | rdEn)) violations++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int quiet = 0;
    reqValid = 4'b0000;
    outReady = 1'b1;
    for (int c = 0; c < 100 && quiet < 2; c++) begin
      tick();
      quiet = (count == 5'd0 && !outValid && !rdEn) ? quiet + 1 : 0;
    end
    testsRun++;
    if (quiet < 2) begin
      testsFailed++;
      $display("[TB] FAIL drain_timeout count=%0d outValid=%0b required idle", count, outValid);
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0; reqValid = 4'b1111; reqData = {4{32'h5555_AAAA}}; outReady = 1'b1;
    forceEmptyLow = 1'b0;
    #2;
    testsRun++; if (reqReady !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_req_ready got=%b want=0000", reqReady); end
    testsRun++; if ({cs, wrEn, rdEn} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_strobes got=%b want=000", {cs, wrEn, rdEn}); end
    testsRun++; if (dataIn !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_data_in got=%h want=0", dataIn); end
    testsRun++; if ({outValid, err} !== 2'b00 || outData !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_out got v=%b e=%b d=%h want 0", outValid, err, outData); end
    tick(); tick();
    rstN = 1'b1;
    #1;
    testsRun++; if (count !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    testsRun++; if (reqReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL reset_first_priority got=%b want=0001", reqReady); end
    reqValid = 4'b0000;
  endtask

  task automatic test_round_robin;
    logic [31:0] nextWord [4];
    gotQ.delete(); expQ.delete();
    for (int j = 0; j < 4; j++) nextWord[j] = 32'hA00 + 32'(j);
    tick();
    outReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) reqData[j*32 +: 32] = nextWord[j];
      reqValid = 4'b1111;
      #1;
      testsRun++; if (reqReady !== (4'b0001 << (k % 4))) begin testsFailed++; $display("[TB] FAIL rr_grant_%0d got=%b want=%b", k, reqReady, 4'b0001 << (k % 4)); end
      testsRun++; if (wrEn !== 1'b1 || dataIn !== 32'hA00 + 32'(k)) begin testsFailed++; $display("[TB] FAIL rr_data_%0d got wr=%b d=%h want wr=1 d=%h", k, wrEn, dataIn, 32'hA00 + 32'(k)); end
      expQ.push_back(32'hA00 + 32'(k));
      nextWord[k % 4] = nextWord[k % 4] + 32'd4;
      tick();
    end
    drain();
    testsRun++; if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL rr_out_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size(); i++) begin
      logic [31:0] g;
      g = (i < gotQ.size()) ? gotQ[i] : 32'hFFFF_FFFF;
      testsRun++; if (g !== expQ[i]) begin testsFailed++; $display("[TB] FAIL rr_out_%0d got=%h want=%h", i, g, expQ[i]); end
    end
  endtask

  task automatic test_full;
    int n = 0;
    int accepted = 0;
    gotQ.delete(); expQ.delete();
    tick();
    outReady = 1'b0;
    for (int c = 0; c < 40; c++) begin
      reqData[2*32 +: 32] = 32'h100 + 32'(n);
      reqValid = 4'b0100;
      #1;
      if (count == 5'd16) break;
      if (reqReady[2]) begin accepted++; n++; end
      tick();
    end
    testsRun++; if (count !== 5'd16) begin testsFailed++; $display("[TB] FAIL full_count got=%0d want=16", count); end
    testsRun++; if (reqReady !== 4'b0000) begin testsFailed++; $display("[TB] FAIL full_req_ready got=%b want=0000", reqReady); end
    // Two words have already moved into the output buffer, so 18 were accepted.
    testsRun++; if (accepted != 18) begin testsFailed++; $display("[TB] FAIL full_accepted got=%0d want=18", accepted); end
    testsRun++; if (outValid !== 1'b1 || outData !== 32'h100) begin testsFailed++; $display("[TB] FAIL full_head got v=%b d=%h want v=1 d=100", outValid, outData); end
    outReady = 1'b1;
    #1;
    testsRun++; if (rdEn !== 1'b1 || reqReady !== 4'b0000) begin testsFailed++; $display("[TB] FAIL full_read_no_write got rd=%b rdy=%b want rd=1 rdy=0000", rdEn, reqReady); end
    tick();
    testsRun++; if (count !== 5'd15 || reqReady !== 4'b0100) begin testsFailed++; $display("[TB] FAIL full_resume got cnt=%0d rdy=%b want cnt=15 rdy=0100", count, reqReady); end
    tick();
    reqValid = 4'b0000;
    drain();
    for (int i = 0; i < 19; i++) expQ.push_back(32'h100 + 32'(i));
    testsRun++; if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL full_out_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size(); i++) begin
      logic [31:0] g;
      g = (i < gotQ.size()) ? gotQ[i] : 32'hFFFF_FFFF;
      testsRun++; if (g !== expQ[i]) begin testsFailed++; $display("[TB] FAIL full_out_%0d got=%h want=%h", i, g, expQ[i]); end
    end
    testsRun++; if (violations != 0) begin testsFailed++; $display("[TB] FAIL full_protocol got=%0d violations want=0", violations); end
  endtask

  task automatic test_latency;
    tick();
    outReady = 1'b1;
    reqData[0 +: 32] = 32'hDEAD_BEEF;
    reqValid = 4'b0001;
    #1;
    testsRun++; if (wrEn !== 1'b1 || reqReady !== 4'b0001 || dataIn !== 32'hDEAD_BEEF || rdEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL lat_write got wr=%b rdy=%b d=%h rd=%b want 1 0001 deadbeef 0", wrEn, reqReady, dataIn, rdEn); end
    tick();
    reqValid = 4'b0000;
    #1;
    testsRun++; if (rdEn !== 1'b1 || count !== 5'd1 || outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL lat_n1 got rd=%b cnt=%0d v=%b want rd=1 cnt=1 v=0", rdEn, count, outValid); end
    tick();
    testsRun++; if (outValid !== 1'b0 || count !== 5'd0) begin testsFailed++; $display("[TB] FAIL lat_n2 got v=%b cnt=%0d want v=0 cnt=0", outValid, count); end
    tick();
    testsRun++; if (outValid !== 1'b1 || outData !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL lat_n3 got v=%b d=%h want v=1 d=deadbeef", outValid, outData); end
    drain();
  endtask

  task automatic test_back_to_back;
    gotQ.delete(); expQ.delete();
    tick();
    outReady = 1'b1;
    for (int k = 0; k < 12; k++) begin
      reqData[1*32 +: 32] = 32'h200 + 32'(k);
      reqValid = 4'b0010;
      #1;
      testsRun++; if (reqReady !== 4'b0010) begin testsFailed++; $display("[TB] FAIL b2b_grant_%0d got=%b want=0010", k, reqReady); end
      testsRun++; if (count !== ((k == 0) ? 5'd0 : 5'd1) || rdEn !== (k != 0)) begin testsFailed++; $display("[TB] FAIL b2b_read_%0d got cnt=%0d rd=%b want cnt=%0d rd=%0b", k, count, rdEn, (k == 0) ? 0 : 1, k != 0); end
      if (k >= 3) begin
        testsRun++; if (outValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_out_valid_%0d got=%b want=1", k, outValid); end
      end
      expQ.push_back(32'h200 + 32'(k));
      tick();
    end
    drain();
    testsRun++; if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL b2b_out_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size(); i++) begin
      logic [31:0] g;
      g = (i < gotQ.size()) ? gotQ[i] : 32'hFFFF_FFFF;
      testsRun++; if (g !== expQ[i]) begin testsFailed++; $display("[TB] FAIL b2b_out_%0d got=%h want=%h", i, g, expQ[i]); end
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    gotQ.delete(); expQ.delete();
    tick();
    for (int c = 0; c < 80 && n < 20; c++) begin
      outReady = (c % 2) == 0;
      reqData[3*32 +: 32] = 32'h300 + 32'(n);
      reqValid = 4'b1000;
      #1;
      if (reqReady[3]) n++;
      tick();
    end
    reqValid = 4'b0000;
    testsRun++; if (n != 20) begin testsFailed++; $display("[TB] FAIL bp_accepted got=%0d want=20", n); end
    drain();
    for (int i = 0; i < 20; i++) expQ.push_back(32'h300 + 32'(i));
    testsRun++; if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL bp_out_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size(); i++) begin
      logic [31:0] g;
      g = (i < gotQ.size()) ? gotQ[i] : 32'hFFFF_FFFF;
      testsRun++; if (g !== expQ[i]) begin testsFailed++; $display("[TB] FAIL bp_out_%0d got=%h want=%h", i, g, expQ[i]); end
    end
    testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_err got=%b want=0", err); end
    testsRun++; if (violations != 0) begin testsFailed++; $display("[TB] FAIL bp_protocol got=%0d violations want=0", violations); end
  endtask

  task automatic test_flag_mismatch;
    tick();
    testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL flag_pre got=%b want=0", err); end
    forceEmptyLow = 1'b1;
    tick();
    forceEmptyLow = 1'b0;
    testsRun++; if (err !== 1'b1) begin testsFailed++; $display("[TB] FAIL flag_set got=%b want=1", err); end
    tick(); tick(); tick();
    testsRun++; if (err !== 1'b1) begin testsFailed++; $display("[TB] FAIL flag_sticky got=%b want=1", err); end
    rstN = 1'b0;
    #1;
    testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL flag_reset got=%b want=0", err); end
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset_mid;
    gotQ.delete();
    tick();
    outReady = 1'b0;
    reqData[0 +: 32] = 32'h400;
    reqValid = 4'b0001;
    repeat (5) tick();
    testsRun++; if (outValid !== 1'b1 || count !== 5'd3) begin testsFailed++; $display("[TB] FAIL mid_pre got v=%b cnt=%0d want v=1 cnt=3", outValid, count); end
    rstN = 1'b0;
    #1;
    testsRun++; if (reqReady !== 4'b0000 || {cs, wrEn, rdEn} !== 3'b000 || dataIn !== 32'd0) begin testsFailed++; $display("[TB] FAIL mid_write_side got rdy=%b s=%b d=%h want 0", reqReady, {cs, wrEn, rdEn}, dataIn); end
    testsRun++; if (outValid !== 1'b0 || outData !== 32'd0 || count !== 5'd0 || err !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_read_side got v=%b d=%h cnt=%0d e=%b want 0", outValid, outData, count, err); end
    tick();
    rstN = 1'b1;
    reqValid = 4'b1111;
    #1;
    testsRun++; if (count !== 5'd0 || outValid !== 1'b0 || reqReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL mid_after got cnt=%0d v=%b rdy=%b want 0 0 0001", count, outValid, reqReady); end
    reqValid = 4'b0000;
    drain();
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    violations = 0;
    test_reset();
    test_round_robin();
    test_full();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_flag_mismatch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
